ad7680_sample_ctrl: RTL and testbench
=====================================

Name: ad7680_sample_ctrl

Overview:
- Sequencer and conditioner wrapped around the AD7680 SPI interface.
- Issues periodic conversion requests on adc_rd_en.
- Captures each returned 16-bit word (adc_data_en/adc_data).
- Supervises each transaction with a timeout.
- Outputs per-sample data and a 2^AVG_LOG2 boxcar average to the slow-device register/telemetry logic.

Parameters:
TRIG_PERIOD, 2000, clk cycles between conversion requests (>= 2)
RD_PULSE_W, 4, adc_rd_en high width in clk cycles (>= 1)
TIMEOUT, 1500, max clk cycles in WAIT before abort (>= 1)
AVG_LOG2, 4, log2 of samples per average (0..8)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
enable  in  1  run sampling; low = abort and hold idle
err_clr  in  1  one-cycle pulse, clears sticky error flags
adc_rd_en  out  1  conversion request to SPI interface (level, rising edge triggers)
adc_data_en  in  1  one-cycle strobe, adc_data valid
adc_data  in  16  converted word
sample_valid  out  1  one-cycle strobe
sample_data  out  16  last accepted sample
avg_valid  out  1  one-cycle strobe
avg_data  out  16  boxcar average
sample_cnt  out  16  accepted samples, wraps 0xFFFF->0
timeout_err  out  1  sticky: transaction timed out
overrun_err  out  1  sticky: period tick while not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, counters and accumulator 0.
- Period counter:
  - enable=0: held at 0.
  - enable=1: counts 0..TRIG_PERIOD-1 and wraps.
  - tick = enable && cnt==TRIG_PERIOD-1, so the first tick is TRIG_PERIOD cycles after enable rises.
- FSM:
  - IDLE: on tick -> TRIG.
  - TRIG: adc_rd_en=1 for exactly RD_PULSE_W cycles (registered; rises the cycle after tick), then -> WAIT with adc_rd_en=0.
  - WAIT: wait counter increments each cycle.
    - adc_data_en=1: accept the sample and go to IDLE.
    - Otherwise, when wait counter==TIMEOUT-1: set timeout_err, no sample produced, go to IDLE.
    - If adc_data_en and the timeout coincide, the sample wins and timeout_err is not set.
  - Tick while in TRIG or WAIT: request is skipped, overrun_err set, FSM unaffected.
- adc_data_en outside WAIT: ignored; no output change.
- Accept at cycle t (adc_data_en sampled high):
  - At t+1: sample_valid=1, sample_data=adc_data, sample_cnt+1.
  - Accumulator (16+AVG_LOG2 bits, unsigned) adds adc_data; sample index n increments.
  - When n reaches 2^AVG_LOG2: avg_data = (acc + adc_data) >> AVG_LOG2 (truncate), avg_valid=1 in the same cycle as that sample_valid; acc and n cleared.
  - AVG_LOG2=0: avg_valid accompanies every sample_valid and avg_data = sample.
- Sticky flags:
  - Set only by their event; cleared by err_clr.
  - Set and err_clr in the same cycle: the flag stays set.
- enable falls: next cycle FSM -> IDLE, adc_rd_en=0, period counter=0, acc and n cleared.
  - sample_data, avg_data, sample_cnt and the error flags are retained.
  - A pending transaction is abandoned; an adc_data_en that arrives later is ignored.
- rst_n low mid-transaction: everything returns to reset values on that edge.
- sample_valid and avg_valid are never high for more than one consecutive cycle per accept.

Test Plan:
- Setup for all tests: TRIG_PERIOD=100, RD_PULSE_W=4, TIMEOUT=60, AVG_LOG2=2; SPI model answers 20 cycles after adc_rd_en rises.
- Reset: hold rst_n=0 with enable=1 -> all outputs 0, no adc_rd_en.
- Basic averaging: enable; model returns 0x1000, 0x2000, 0x3000, 0x4001 -> adc_rd_en high 4 cycles, rising every 100 cycles; four sample_valid with matching sample_data one cycle after each adc_data_en; sample_cnt=4; one avg_valid coincident with the 4th sample, avg_data=0x2800.
- No width overflow: 4 samples of 0xFFFF -> avg_data=0xFFFF.
- Timeout: model silent -> timeout_err rises 64 cycles after adc_rd_en rises; sample_cnt unchanged; next adc_rd_en still at +100. Then err_clr coincident with a second timeout -> timeout_err remains 1; err_clr alone -> 0.
- Abort mid-average: 2 samples, drop enable mid-WAIT, late adc_data_en arrives -> ignored. Re-enable with samples 8, 8, 8, 8 -> avg_data=8 (accumulator was cleared).
- Boundaries and overrun:
  - Spurious adc_data_en in IDLE -> no sample_valid.
  - adc_data_en exactly on the timeout cycle -> sample accepted, timeout_err=0.
  - Rebuild with TIMEOUT=200 and model silent -> overrun_err=1 at the first tick during WAIT.

Source files
------------

// File: rtl/ad7680_sample_ctrl_if.sv
// Handshake between the sample controller and the AD7680 SPI front end.
// The controller raises adc_rd_en; the front end returns one word with a one-cycle strobe.
interface ad7680_sample_ctrl_if;
  logic        adc_rd_en;
  logic        adc_data_en;
  logic [15:0] adc_data;

  modport master (output adc_rd_en, input adc_data_en, input adc_data);
  modport slave  (input adc_rd_en, output adc_data_en, output adc_data);
endinterface

// File: rtl/ad7680_sample_ctrl.sv
// Periodic AD7680 conversion sequencer with transaction timeout, per-sample output
// and a 2^AVG_LOG2 boxcar average, plus sticky timeout/overrun flags.
module ad7680_sample_ctrl #(
  parameter int TRIG_PERIOD = 2000,
  parameter int RD_PULSE_W  = 4,
  parameter int TIMEOUT     = 1500,
  parameter int AVG_LOG2    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_err_clr,
  ad7680_sample_ctrl_if.master adc,
  output logic                 o_sample_valid,
  output logic [15:0]          o_sample_data,
  output logic                 o_avg_valid,
  output logic [15:0]          o_avg_data,
  output logic [15:0]          o_sample_cnt,
  output logic                 o_timeout_err,
  output logic                 o_overrun_err
);
  localparam int PER_W = $clog2(TRIG_PERIOD);
  localparam int PUL_W = (RD_PULSE_W > 1) ? $clog2(RD_PULSE_W) : 1;
  localparam int WT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(TRIG_PERIOD - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RD_PULSE_W - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(TIMEOUT - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PER_W-1:0]   r_per_cnt;
  logic [PUL_W-1:0]   r_pul_cnt;
  logic [WT_W-1:0]    r_wait_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [N_W-1:0]     r_n;
  logic               r_rd_en;
  logic               r_sample_valid;
  logic [15:0]        r_sample_data;
  logic               r_avg_valid;
  logic [15:0]        r_avg_data;
  logic [15:0]        r_sample_cnt;
  logic               r_timeout_err;
  logic               r_overrun_err;
  logic               w_tick;
  logic               w_accept;
  logic               w_timeout;
  logic               w_overrun;
  logic               w_avg_last;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [ACC_W-1:0]   w_avg_shift;

  assign w_tick      = i_enable && (r_per_cnt == PER_LAST);
  assign w_overrun   = w_tick && (r_state != S_IDLE);
  assign w_avg_last  = (r_n == N_LAST);
  assign w_acc_sum   = r_acc + ACC_W'(adc.adc_data);
  assign w_avg_shift = w_acc_sum >> AVG_LOG2;

  // Period counter: held at zero while disabled, free-running otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_per_cnt <= {PER_W{1'b0}};
    end else if (!i_enable || (r_per_cnt == PER_LAST)) begin
      r_per_cnt <= {PER_W{1'b0}};
    end else begin
      r_per_cnt <= r_per_cnt + PER_W'(1);
    end
  end

  // Next-state logic; dropping enable abandons whatever transaction is pending
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_state_nxt = S_TRIG;
        else        w_state_nxt = S_IDLE;
      end
      S_TRIG: begin
        if (!i_enable)                   w_state_nxt = S_IDLE;
        else if (r_pul_cnt == PUL_LAST)  w_state_nxt = S_WAIT;
        else                             w_state_nxt = S_TRIG;
      end
      S_WAIT: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (adc.adc_data_en) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == WT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, request pulse and in-state cycle counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_pul_cnt  <= {PUL_W{1'b0}};
      r_wait_cnt <= {WT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_rd_en <= (w_state_nxt == S_TRIG);
      if ((r_state == S_TRIG) && (w_state_nxt == S_TRIG)) r_pul_cnt <= r_pul_cnt + PUL_W'(1);
      else                                              r_pul_cnt <= {PUL_W{1'b0}};
      if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) r_wait_cnt <= r_wait_cnt + WT_W'(1);
      else                                              r_wait_cnt <= {WT_W{1'b0}};
    end
  end

  // Sample capture and boxcar accumulation; the accumulator is sized so a full block cannot overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample_valid <= 1'b0;
      r_avg_valid    <= 1'b0;
      r_sample_data  <= 16'h0000;
      r_avg_data     <= 16'h0000;
      r_sample_cnt   <= 16'h0000;
      r_acc          <= {ACC_W{1'b0}};
      r_n            <= {N_W{1'b0}};
    end else begin
      r_sample_valid <= w_accept;
      r_avg_valid    <= w_accept && w_avg_last;
      if (!i_enable) begin
        r_acc <= {ACC_W{1'b0}};
        r_n   <= {N_W{1'b0}};
      end else if (w_accept) begin
        r_sample_data <= adc.adc_data;
        r_sample_cnt  <= r_sample_cnt + 16'd1;
        if (w_avg_last) begin
          r_avg_data <= w_avg_shift[15:0];
          r_acc      <= {ACC_W{1'b0}};
          r_n        <= {N_W{1'b0}};
        end else begin
          r_acc <= w_acc_sum;
          r_n   <= r_n + N_W'(1);
        end
      end
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_timeout)      r_timeout_err <= 1'b1;
      else if (i_err_clr) r_timeout_err <= 1'b0;
      if (w_overrun)      r_overrun_err <= 1'b1;
      else if (i_err_clr) r_overrun_err <= 1'b0;
    end
  end

  assign adc.adc_rd_en   = r_rd_en;
  assign o_sample_valid  = r_sample_valid;
  assign o_sample_data   = r_sample_data;
  assign o_avg_valid     = r_avg_valid;
  assign o_avg_data      = r_avg_data;
  assign o_sample_cnt    = r_sample_cnt;
  assign o_timeout_err   = r_timeout_err;
  assign o_overrun_err   = r_overrun_err;
endmodule

// File: tb/tb_ad7680_sample_ctrl.sv
// Bench for ad7680_sample_ctrl: a table of ADC answers with expected averages, a scoreboard
// on the sample/avg strobes, and hand-written sequences for timeout, abort, boundary and overrun.
module tb_ad7680_sample_ctrl;
  localparam int P = 100;
  localparam int W = 4;
  localparam int T = 60;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n, en, err_clr, en2;
  always #5 clk = ~clk;

  ad7680_sample_ctrl_if adc_if ();
  ad7680_sample_ctrl_if adc2_if ();

  logic        sv, av, to_err, ov_err, sv2, av2, to2, ov2;
  logic [15:0] sd, ad, scnt, sd2, ad2, scnt2;

  ad7680_sample_ctrl #(.TRIG_PERIOD(P), .RD_PULSE_W(W), .TIMEOUT(T), .AVG_LOG2(L)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_err_clr(err_clr), .adc(adc_if.master),
    .o_sample_valid(sv), .o_sample_data(sd), .o_avg_valid(av), .o_avg_data(ad),
    .o_sample_cnt(scnt), .o_timeout_err(to_err), .o_overrun_err(ov_err));

  ad7680_sample_ctrl #(.TRIG_PERIOD(P), .RD_PULSE_W(W), .TIMEOUT(200), .AVG_LOG2(L)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_enable(en2), .i_err_clr(err_clr), .adc(adc2_if.master),
    .o_sample_valid(sv2), .o_sample_data(sd2), .o_avg_valid(av2), .o_avg_data(ad2),
    .o_sample_cnt(scnt2), .o_timeout_err(to2), .o_overrun_err(ov2));

  typedef struct {
    logic [15:0] word;
    int          dly;
    logic        avg_v;
    logic [15:0] avg;
  } vec_t;

  vec_t        vt [15];
  logic [15:0] exp_sq [$];
  logic [15:0] exp_aq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  int          last_rise = -1;
  int          en_cyc = 0;
  logic        prev_sv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the head of the expected queues
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sv === 1'b1) begin
        check("sample_valid single cycle", prev_sv, 1'b0);
        if (exp_sq.size() == 0) check("unexpected sample_valid", 1'b1, 1'b0);
        else                    check("sample_data", sd, exp_sq.pop_front());
      end
      if (av === 1'b1) begin
        check("avg_valid with sample_valid", sv, 1'b1);
        if (exp_aq.size() == 0) check("unexpected avg_valid", 1'b1, 1'b0);
        else                    check("avg_data", ad, exp_aq.pop_front());
      end
      prev_sv = sv;
    end
  end

  task automatic wait_rise(output int rc);
    rc = -1;
    for (int j = 0; j < 300; j++) begin
      @(posedge clk); #1;
      if (adc_if.adc_rd_en === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) check("adc_rd_en rise within budget", 1'b0, 1'b1);
    else if (last_rise < 0) check("first request latency", rc - en_cyc, P);
    else check("request period", rc - last_rise, P);
    last_rise = rc;
  endtask

  task automatic do_vec(input int i);
    int rc;
    int hi;
    wait_rise(rc);
    hi = 1;
    for (int j = 1; j <= vt[i].dly; j++) begin
      @(posedge clk); #1;
      if (adc_if.adc_rd_en === 1'b1) hi++;
    end
    check("adc_rd_en width", hi, W);
    adc_if.adc_data    = vt[i].word;
    adc_if.adc_data_en = 1'b1;
    exp_sq.push_back(vt[i].word);
    exp_cnt++;
    if (vt[i].avg_v) exp_aq.push_back(vt[i].avg);
    @(posedge clk); #1;
    adc_if.adc_data_en = 1'b0;
    check("sample_cnt", scnt, exp_cnt);
  endtask

  task automatic silent(input logic clr_on_timeout);
    int rc;
    int tc;
    wait_rise(rc);
    if (clr_on_timeout) begin
      for (int j = 1; j <= 63; j++) begin
        @(posedge clk); #1;
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check("timeout_err set beats clear", to_err, 1'b1);
    end else begin
      tc = -1;
      for (int j = 0; j < 200; j++) begin
        @(posedge clk); #1;
        if (to_err === 1'b1) begin
          tc = cyc;
          break;
        end
      end
      check("timeout latency", tc - rc, 64);
    end
    check("sample_cnt after timeout", scnt, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rc;
    int e2;
    vt[0]  = '{16'h1000, 20, 1'b0, 16'h0000};
    vt[1]  = '{16'h2000, 20, 1'b0, 16'h0000};
    vt[2]  = '{16'h3000, 20, 1'b0, 16'h0000};
    vt[3]  = '{16'h4001, 20, 1'b1, 16'h2800};
    vt[4]  = '{16'hFFFF, 20, 1'b0, 16'h0000};
    vt[5]  = '{16'hFFFF, 20, 1'b0, 16'h0000};
    vt[6]  = '{16'hFFFF, 20, 1'b0, 16'h0000};
    vt[7]  = '{16'hFFFF, 20, 1'b1, 16'hFFFF};
    vt[8]  = '{16'h0100, 20, 1'b0, 16'h0000};
    vt[9]  = '{16'h0300, 20, 1'b0, 16'h0000};
    vt[10] = '{16'h0008, 20, 1'b0, 16'h0000};
    vt[11] = '{16'h0008, 20, 1'b0, 16'h0000};
    vt[12] = '{16'h0008, 20, 1'b0, 16'h0000};
    vt[13] = '{16'h0008, 20, 1'b1, 16'h0008};
    vt[14] = '{16'h1234, 63, 1'b0, 16'h0000};

    rst_n = 1'b0; en = 1'b1; en2 = 1'b0; err_clr = 1'b0;
    adc_if.adc_data_en = 1'b0;  adc_if.adc_data = 16'h0000;
    adc2_if.adc_data_en = 1'b0; adc2_if.adc_data = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    check("reset flags/strobes", {sv, av, to_err, ov_err, adc_if.adc_rd_en}, 5'b00000);
    check("reset data", {sd, ad}, 32'h0);
    check("reset sample_cnt", scnt, 16'h0000);

    en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    en = 1'b1; en_cyc = cyc; last_rise = -1;
    for (int i = 0; i < 8; i++) do_vec(i);

    silent(1'b0);
    silent(1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("timeout_err cleared", to_err, 1'b0);

    // Two samples into a block, then abort mid-WAIT with a late answer
    for (int i = 8; i < 10; i++) do_vec(i);
    wait_rise(rc);
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("adc_rd_en low after abort", adc_if.adc_rd_en, 1'b0);
    adc_if.adc_data = 16'hBEEF; adc_if.adc_data_en = 1'b1;
    @(posedge clk); #1;
    adc_if.adc_data_en = 1'b0;
    check("late answer ignored", sv, 1'b0);
    check("sample_data retained", sd, 16'h0300);
    check("sample_cnt retained", scnt, exp_cnt);

    en = 1'b1; en_cyc = cyc; last_rise = -1;
    for (int i = 10; i < 14; i++) do_vec(i);

    adc_if.adc_data = 16'hDEAD; adc_if.adc_data_en = 1'b1;
    @(posedge clk); #1;
    adc_if.adc_data_en = 1'b0;
    check("spurious in IDLE ignored", sv, 1'b0);
    check("sample_cnt after spurious", scnt, exp_cnt);

    do_vec(14);
    check("no timeout on coincident accept", to_err, 1'b0);
    check("no overrun on main unit", ov_err, 1'b0);

    // Reset in the middle of a transaction
    wait_rise(rc);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid reset flags/strobes", {sv, av, to_err, ov_err, adc_if.adc_rd_en}, 5'b00000);
    check("mid reset data/cnt", {sd, ad, scnt}, 48'h0);
    en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Long timeout: the next period tick lands inside WAIT
    en2 = 1'b1; e2 = cyc; rc = -1;
    for (int j = 0; j < 400; j++) begin
      @(posedge clk); #1;
      if (ov2 === 1'b1) begin
        rc = cyc;
        break;
      end
    end
    check("overrun latency", rc - e2, 200);
    @(posedge clk); #1;
    check("overrun request skipped", adc2_if.adc_rd_en, 1'b0);
    check("overrun unit no samples", {sv2, av2, sd2, ad2, scnt2, to2}, 50'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sample queue drained", exp_sq.size(), 0);
    check("avg queue drained", exp_aq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
